fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR filter engine. A single shared signed WIDTH×WIDTH multiplier produces a 2·WIDTH product, and this block sequences it over TAPS coefficient/sample pairs per input sample. It owns the delay line, the coefficient registers and the accumulator. Samples enter through a valid/ready handshake, and each filtered result leaves as a one-cycle valid pulse.

---
 rtl/fir_mac_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR engine built around one shared
// signed WIDTH x WIDTH multiplier. For each accepted sample it steps through
// the TAPS coefficient/sample pairs, accumulates the products and emits the
// filter result as a single-cycle out_valid pulse.
// Optional feature macro: FIR_SAT_EN. When it is defined, the result is
// clamped to the 2*WIDTH signed range and out_sat flags the clip. When it is
// undefined, the result wraps and out_sat is tied to 0.
module fir_mac_sequencer #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8,
    localparam int AW   = $clog2(TAPS),
    localparam int PW   = 2 * WIDTH,
    localparam int ACCW = PW + AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [WIDTH-1:0] coef_data,
    output logic                    out_valid,
    output logic signed [PW-1:0]    out_data,
    output logic                    out_sat,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_DONE} state_t;

    state_t state_reg, state_next;

    logic signed [WIDTH-1:0] coef_reg [TAPS];
    logic signed [WIDTH-1:0] line_reg [TAPS];
    logic [AW-1:0]           wr_ptr_reg;
    logic [AW-1:0]           idx_reg;
    logic signed [ACCW-1:0]  acc_reg;
    logic signed [PW-1:0]    prod_reg;
    logic signed [PW-1:0]    out_data_reg;
    logic                    out_sat_reg;
    logic                    out_valid_reg;

    logic                    idle;
    logic                    accept;
    logic [AW-1:0]           rd_ptr;
    logic signed [PW-1:0]    prod_next;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [PW-1:0]    res_data;
    logic                    res_sat;

    assign idle      = (state_reg == S_IDLE);
    assign accept    = idle && in_valid;
    assign in_ready  = idle;
    assign busy      = !idle;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

    // The delay line index wraps naturally because TAPS is a power of two.
    assign rd_ptr    = wr_ptr_reg - idx_reg;
    assign prod_next = PW'(coef_reg[idx_reg]) * PW'(line_reg[rd_ptr]);
    assign acc_sum   = acc_reg + ACCW'(prod_reg);

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            // Per-tap coefficient register; writes land only while idle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    coef_reg[gi] <= '0;
                end else if (coef_we && idle && coef_addr == AW'(gi)) begin
                    coef_reg[gi] <= coef_data;
                end
            end

            // Per-tap delay-line entry; the accepted sample goes to wr_ptr.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    line_reg[gi] <= '0;
                end else if (accept && wr_ptr_reg == AW'(gi)) begin
                    line_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Narrow the final accumulator sum to the 2*WIDTH output.
`ifdef FIR_SAT_EN
    logic ovf;
    always_comb begin
        ovf      = !((&acc_sum[ACCW-1:PW-1]) || !(|acc_sum[ACCW-1:PW-1]));
        res_data = acc_sum[PW-1:0];
        res_sat  = 1'b0;
        if (ovf) begin
            res_sat  = 1'b1;
            res_data = acc_sum[ACCW-1] ? {1'b1, {(PW-1){1'b0}}}
                                       : {1'b0, {(PW-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_data = acc_sum[PW-1:0];
        res_sat  = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> MAC (TAPS cycles) -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_MAC;
            S_MAC:   if (idx_reg == AW'(TAPS - 1)) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: product pipeline, accumulator, result register and pointers.
    // The result is registered on the DRAIN edge, so the out_valid pulse
    // coincides with the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            idx_reg       <= '0;
            acc_reg       <= '0;
            prod_reg      <= '0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        acc_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                S_MAC: begin
                    prod_reg <= prod_next;
                    // prod_reg holds nothing useful during the first MAC cycle.
                    if (idx_reg != '0) begin
                        acc_reg <= acc_sum;
                    end
                    idx_reg <= idx_reg + 1'b1;
                end
                S_DRAIN: begin
                    acc_reg       <= acc_sum;
                    out_data_reg  <= res_data;
                    out_sat_reg   <= res_sat;
                    out_valid_reg <= 1'b1;
                end
                S_DONE: begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed table-driven bench for fir_mac_sequencer
// (WIDTH=16, TAPS=4), plus hand-written busy and mid-run reset sequences.
module tb_fir_mac_sequencer;

    localparam int WIDTH = 16;
    localparam int TAPS  = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic               coef_we = 1'b0;
    logic [1:0]         coef_addr = '0;
    logic [WIDTH-1:0]   coef_data = '0;
    logic               out_valid;
    logic [2*WIDTH-1:0] out_data;
    logic               out_sat;
    logic               busy;

    int errors = 0;
    int checks = 0;

    fir_mac_sequencer #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_coef;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [31:0] exp_data;
        bit          exp_sat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t cw(input int a, input logic [15:0] d);
        vec_t v;
        v.is_coef = 1'b1; v.addr = 2'(a); v.data = d; v.exp_data = '0; v.exp_sat = 1'b0;
        return v;
    endfunction

    function automatic vec_t smp(input logic [15:0] d, input logic [31:0] e, input bit s);
        vec_t v;
        v.is_coef = 1'b0; v.addr = '0; v.data = d; v.exp_data = e; v.exp_sat = s;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk);
        #1 coef_we = 1'b0;
        $display("coef[%0d] <= %h", a, d);
    endtask

    // Offers one sample, then watches 8 edges for latency, pulse count and in_ready.
    task automatic do_sample(input logic [15:0] d, output logic [31:0] res, output logic sat_o);
        int lat = 0;
        int pulses = 0;
        bit ready_bad = 1'b0;
        res = '0; sat_o = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++; lat = c; res = out_data; sat_o = out_sat;
            end
            if (c <= 5 && in_ready) ready_bad = 1'b1;
            if (c == 6 && !in_ready) ready_bad = 1'b1;
        end
        check("out_latency", 32'(lat), 32'd5);
        check("out_pulses", 32'(pulses), 32'd1);
        check("in_ready_window", 32'(ready_bad), 32'd0);
        $display("sample %h -> out %h sat %b latency %0d", d, res, sat_o, lat);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        logic [31:0] r;
        logic        s;
        if (v.is_coef) begin
            write_coef(v.addr, v.data);
        end else begin
            do_sample(v.data, r, s);
            check($sformatf("vec%0d_data", i), r, v.exp_data);
            check($sformatf("vec%0d_sat", i), 32'(s), 32'(v.exp_sat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] vals [2];
        int          edges [2];
        int          np;
        int          stray;

        // Impulse response.
        vecs.push_back(cw(0, 16'd1)); vecs.push_back(cw(1, 16'd2));
        vecs.push_back(cw(2, 16'd3)); vecs.push_back(cw(3, 16'd4));
        vecs.push_back(smp(16'd1, 32'd1, 0)); vecs.push_back(smp(16'd0, 32'd2, 0));
        vecs.push_back(smp(16'd0, 32'd3, 0)); vecs.push_back(smp(16'd0, 32'd4, 0));
        vecs.push_back(smp(16'd0, 32'd0, 0));
        // Signed math.
        vecs.push_back(cw(0, 16'hFFFE)); vecs.push_back(cw(1, 16'h0));
        vecs.push_back(cw(2, 16'h0));    vecs.push_back(cw(3, 16'h0));
        vecs.push_back(smp(16'hFFFD, 32'd6, 0));
        vecs.push_back(cw(0, 16'h8000));
        vecs.push_back(smp(16'h7FFF, 32'hC0008000, 0));
        // Three zero samples so the next sample overwrites the 0x7FFF slot.
        vecs.push_back(smp(16'h0, 32'h0, 0)); vecs.push_back(smp(16'h0, 32'h0, 0));
        vecs.push_back(smp(16'h0, 32'h0, 0));
        // Overflow.
        vecs.push_back(cw(0, 16'h7FFF)); vecs.push_back(cw(1, 16'h7FFF));
        vecs.push_back(cw(2, 16'h7FFF)); vecs.push_back(cw(3, 16'h7FFF));
        vecs.push_back(smp(16'h7FFF, 32'h3FFF0001, 0));
        vecs.push_back(smp(16'h7FFF, 32'h7FFE0002, 0));
`ifdef FIR_SAT_EN
        vecs.push_back(smp(16'h7FFF, 32'h7FFFFFFF, 1));
        vecs.push_back(smp(16'h7FFF, 32'h7FFFFFFF, 1));
`else
        vecs.push_back(smp(16'h7FFF, 32'hBFFD0003, 0));
        vecs.push_back(smp(16'h7FFF, 32'hFFFC0004, 0));
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Busy handling: coef write and a held second sample during MAC.
        write_coef(2'd0, 16'd5); write_coef(2'd1, 16'd0);
        write_coef(2'd2, 16'd0); write_coef(2'd3, 16'd0);
        np = 0; vals[0] = '0; vals[1] = '0; edges[0] = -1; edges[1] = -1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd2;
        for (int e = 0; e <= 15; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (np < 2) begin vals[np] = out_data; edges[np] = e; end
                np++;
            end
            @(negedge clk);
            if (e == 0) begin
                in_data = 16'd3;
                coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd100;
            end
            if (e == 1) coef_we = 1'b0;
            if (e == 7) in_valid = 1'b0;
        end
        $display("busy run: %0d results, %h at E%0d, %h at E%0d", np, vals[0], edges[0], vals[1], edges[1]);
        check("busy_pulses", 32'(np), 32'd2);
        check("busy_first", vals[0], 32'd10);
        check("busy_first_edge", 32'(edges[0]), 32'd5);
        check("busy_second", vals[1], 32'd15);
        check("busy_second_edge", 32'(edges[1]), 32'd12);

        // Reset in the second MAC cycle.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset mid-run asserted");
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_sat", 32'(out_sat), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check("midrst_no_out_valid", 32'(stray), 32'd0);

        vecs.delete();
        vecs.push_back(cw(0, 16'd1)); vecs.push_back(cw(1, 16'd2));
        vecs.push_back(cw(2, 16'd3)); vecs.push_back(cw(3, 16'd4));
        vecs.push_back(smp(16'd1, 32'd1, 0)); vecs.push_back(smp(16'd0, 32'd2, 0));
        vecs.push_back(smp(16'd0, 32'd3, 0)); vecs.push_back(smp(16'd0, 32'd4, 0));
        foreach (vecs[i]) run_vec(vecs[i], 100 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
